tx_frame_sequencer: RTL and testbench

- Sequences one outgoing frame from the HPS-filled TX byte FIFO into the modem transmitter, replacing direct software pacing of FIFO reads.
- On a start pulse it checks FIFO occupancy, reads exactly frame_len bytes, and hands each byte over a valid/ready handshake.
- After the last byte it holds off for a programmable guard interval, then raises a sticky completion interrupt for the HPS driver.

---
 rtl/tx_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: moves one frame of frame_len bytes from the TX FIFO
// to the modem transmitter, then waits a guard interval and raises a sticky interrupt.
module tx_frame_sequencer #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int GUARD_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [GUARD_W-1:0] guard_interval,
    input  logic [LEN_W-1:0]   fifo_count,
    input  logic [DATA_W-1:0]  fifo_data,
    output logic               fifo_rden,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done_irq,
    output logic               underrun,
    input  logic               irq_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_SEND,
        S_GUARD,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [LEN_W-1:0]   remaining;
    logic [GUARD_W-1:0] guard_cnt;
    logic               start_accept;
    logic               fifo_short;
    logic               last_byte;
    logic               set_done;
    logic               set_underrun;

    assign start_accept = (state == S_IDLE) && start && (frame_len != '0);
    assign fifo_short   = (fifo_count < remaining);
    // remaining is never 0 in SEND, but treat <=1 as last so it cannot wrap
    assign last_byte    = (remaining <= LEN_W'(1));
    assign set_underrun = (state == S_CHECK) && fifo_short;
    assign set_done     = set_underrun || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fifo_rden  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_accept) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                next_state = fifo_short ? S_IDLE : S_READ;
            end
            S_READ: begin
                fifo_rden  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                next_state = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (last_byte) begin
                        next_state = (guard_cnt != '0) ? S_GUARD : S_DONE;
                    end else begin
                        next_state = S_READ;
                    end
                end
            end
            S_GUARD: begin
                if (guard_cnt <= GUARD_W'(1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            guard_cnt <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_accept) begin
                        remaining <= frame_len;
                        guard_cnt <= guard_interval;
                    end
                end
                S_WAIT: begin
                    tx_data  <= fifo_data;
                    tx_valid <= 1'b1;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                S_GUARD: begin
                    if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - GUARD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A flag being set in the same cycle as irq_ack keeps the set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_irq <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (set_done) begin
                done_irq <= 1'b1;
            end else if (irq_ack) begin
                done_irq <= 1'b0;
            end
            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (irq_ack) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer: FIFO memory model, handshake monitor
// and a frame-level timing model (busy lasts 3*len + guard + 2 + stall cycles).
module tb_tx_frame_sequencer;

    localparam int DATA_W  = 8;
    localparam int LEN_W   = 8;
    localparam int GUARD_W = 32;

    logic               clk;
    logic               reset;
    logic               start;
    logic [LEN_W-1:0]   frame_len;
    logic [GUARD_W-1:0] guard_interval;
    logic [LEN_W-1:0]   fifo_count;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_rden;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               done_irq;
    logic               underrun;
    logic               irq_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] mem [0:2047];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic [DATA_W-1:0] rx_q[$];
    int hs_cyc[$];
    int cyc        = 0;
    int rden_cnt   = 0;
    int stall_cnt  = 0;
    int rden_viol  = 0;
    int hold_viol  = 0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    tx_frame_sequencer #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .GUARD_W(GUARD_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .frame_len(frame_len),
        .guard_interval(guard_interval),
        .fifo_count(fifo_count),
        .fifo_data(fifo_data),
        .fifo_rden(fifo_rden),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done_irq(done_irq),
        .underrun(underrun),
        .irq_ack(irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Handshake monitor: records accepted bytes and protocol violations
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rden) rden_cnt <= rden_cnt + 1;
        if (fifo_rden && tx_valid) rden_viol <= rden_viol + 1;
        if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            hs_cyc.push_back(cyc);
        end
        if (tx_valid && !tx_ready) stall_cnt <= stall_cnt + 1;
        if (!reset && prev_stall && (!tx_valid || tx_data != prev_data))
            hold_viol <= hold_viol + 1;
        prev_stall <= !reset && tx_valid && !tx_ready;
        prev_data  <= tx_data;
    end

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = 8'($urandom);
            wr_ptr++;
        end
    endtask

    task automatic ack_flags();
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    // Runs one frame; count_ovr < 0 means fifo_count reflects true occupancy
    task automatic run_frame(input int len, input int guard, input int count_ovr,
                             input bit rand_ready, input int first_hold,
                             input int restart_at, output int busy_cyc,
                             output int start_cyc);
        int k;
        int hold;
        int occ;
        hold = first_hold;
        @(negedge clk);
        occ = wr_ptr - rd_ptr;
        if (occ > 255) occ = 255;
        frame_len      = LEN_W'(len);
        guard_interval = GUARD_W'(guard);
        fifo_count     = (count_ovr < 0) ? LEN_W'(occ) : LEN_W'(count_ovr);
        tx_ready       = 1'b1;
        start          = 1'b1;
        start_cyc      = cyc;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        k        = 0;
        while (busy) begin
            busy_cyc++;
            if (tx_valid && hold > 0) begin
                tx_ready = 1'b0;
                hold--;
            end else begin
                tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = (k == restart_at);
            k++;
            if (k > 5000) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL frame_timeout busy=%0b required=0 within 5000 cycles", busy);
                break;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_cmp++; if (fifo_rden !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fifo_rden got=%b exp=0", fifo_rden); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_cmp++; if (done_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done_irq got=%b exp=0", done_irq); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] exp [3];
        int rx0, hs0, rd0, bc, sc;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            mem[wr_ptr] = exp[i];
            wr_ptr++;
        end
        rx0 = rx_q.size(); hs0 = hs_cyc.size(); rd0 = rden_cnt;
        run_frame(3, 0, -1, 1'b0, 0, -1, bc, sc);
        n_cmp++; if (rx_q.size() - rx0 !== 3) begin n_fail++; $display("[TB] FAIL basic_count got=%0d exp=3", rx_q.size() - rx0); end
        for (int i = 0; i < 3; i++) begin
            if (rx0 + i < rx_q.size()) begin
                n_cmp++;
                if (rx_q[rx0 + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL basic_byte%0d got=%h exp=%h", i, rx_q[rx0 + i], exp[i]); end
            end
        end
        if (hs_cyc.size() - hs0 == 3) begin
            n_cmp++; if (hs_cyc[hs0] - sc !== 4) begin n_fail++; $display("[TB] FAIL basic_latency got=%0d exp=4", hs_cyc[hs0] - sc); end
            n_cmp++; if (hs_cyc[hs0 + 1] - hs_cyc[hs0] !== 3) begin n_fail++; $display("[TB] FAIL basic_spacing1 got=%0d exp=3", hs_cyc[hs0 + 1] - hs_cyc[hs0]); end
            n_cmp++; if (hs_cyc[hs0 + 2] - hs_cyc[hs0 + 1] !== 3) begin n_fail++; $display("[TB] FAIL basic_spacing2 got=%0d exp=3", hs_cyc[hs0 + 2] - hs_cyc[hs0 + 1]); end
        end
        n_cmp++; if (rden_cnt - rd0 !== 3) begin n_fail++; $display("[TB] FAIL basic_rden got=%0d exp=3", rden_cnt - rd0); end
        n_cmp++; if (bc !== 11) begin n_fail++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=11", bc); end
        n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done_irq got=%b exp=1", done_irq); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_underrun got=%b exp=0", underrun); end
        ack_flags();
        n_cmp++; if (done_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ack got=%b exp=0", done_irq); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp [2];
        int rx0, rd0, st0, hv0, rv0, bc, sc;
        write_bytes(2);
        exp[0] = mem[rd_ptr]; exp[1] = mem[rd_ptr + 1];
        rx0 = rx_q.size(); rd0 = rden_cnt; st0 = stall_cnt; hv0 = hold_viol; rv0 = rden_viol;
        run_frame(2, 0, -1, 1'b0, 5, -1, bc, sc);
        n_cmp++; if (rx_q.size() - rx0 !== 2) begin n_fail++; $display("[TB] FAIL bp_count got=%0d exp=2", rx_q.size() - rx0); end
        for (int i = 0; i < 2; i++) begin
            if (rx0 + i < rx_q.size()) begin
                n_cmp++;
                if (rx_q[rx0 + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL bp_byte%0d got=%h exp=%h", i, rx_q[rx0 + i], exp[i]); end
            end
        end
        n_cmp++; if (stall_cnt - st0 !== 5) begin n_fail++; $display("[TB] FAIL bp_stalls got=%0d exp=5", stall_cnt - st0); end
        n_cmp++; if (hold_viol - hv0 !== 0) begin n_fail++; $display("[TB] FAIL bp_hold_stable got=%0d exp=0", hold_viol - hv0); end
        n_cmp++; if (rden_viol - rv0 !== 0) begin n_fail++; $display("[TB] FAIL bp_rden_while_valid got=%0d exp=0", rden_viol - rv0); end
        n_cmp++; if (rden_cnt - rd0 !== 2) begin n_fail++; $display("[TB] FAIL bp_rden got=%0d exp=2", rden_cnt - rd0); end
        n_cmp++; if (bc !== 13) begin n_fail++; $display("[TB] FAIL bp_busy_cycles got=%0d exp=13", bc); end
        ack_flags();
    endtask

    task automatic test_underrun();
        int rx0, rd0, bc, sc;
        write_bytes(2);
        rx0 = rx_q.size(); rd0 = rden_cnt;
        run_frame(4, 0, 2, 1'b0, 0, -1, bc, sc);
        n_cmp++; if (bc !== 1) begin n_fail++; $display("[TB] FAIL ur_busy_cycles got=%0d exp=1", bc); end
        n_cmp++; if (rden_cnt - rd0 !== 0) begin n_fail++; $display("[TB] FAIL ur_rden got=%0d exp=0", rden_cnt - rd0); end
        n_cmp++; if (rx_q.size() - rx0 !== 0) begin n_fail++; $display("[TB] FAIL ur_bytes got=%0d exp=0", rx_q.size() - rx0); end
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ur_flag got=%b exp=1", underrun); end
        n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL ur_done_irq got=%b exp=1", done_irq); end
        ack_flags();
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ur_ack got=%b exp=0", underrun); end
    endtask

    task automatic test_guard_ack();
        int bc, sc;
        write_bytes(1);
        run_frame(1, 10, -1, 1'b0, 0, -1, bc, sc);
        n_cmp++; if (bc !== 15) begin n_fail++; $display("[TB] FAIL guard_busy_cycles got=%0d exp=15", bc); end
        n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL guard_done_irq got=%b exp=1", done_irq); end
        ack_flags();
        n_cmp++; if (done_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL guard_ack got=%b exp=0", done_irq); end
        write_bytes(1);
        irq_ack = 1'b1;
        run_frame(1, 3, -1, 1'b0, 0, -1, bc, sc);
        n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL set_wins got=%b exp=1", done_irq); end
        n_cmp++; if (bc !== 8) begin n_fail++; $display("[TB] FAIL guard3_busy_cycles got=%0d exp=8", bc); end
        @(negedge clk);
        irq_ack = 1'b0;
        n_cmp++; if (done_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL late_ack got=%b exp=0", done_irq); end
    endtask

    task automatic test_ignored_start();
        int rd0, rx0, busy_seen, bc, sc;
        logic [DATA_W-1:0] exp [4];
        rd0 = rden_cnt; busy_seen = 0;
        @(negedge clk);
        frame_len = '0; guard_interval = '0; fifo_count = 8'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        n_cmp++; if (busy_seen !== 0) begin n_fail++; $display("[TB] FAIL zero_len_busy got=%0d exp=0", busy_seen); end
        n_cmp++; if (rden_cnt - rd0 !== 0) begin n_fail++; $display("[TB] FAIL zero_len_rden got=%0d exp=0", rden_cnt - rd0); end
        n_cmp++; if (done_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_len_irq got=%b exp=0", done_irq); end
        write_bytes(4);
        for (int i = 0; i < 4; i++) exp[i] = mem[rd_ptr + i];
        rd0 = rden_cnt; rx0 = rx_q.size();
        run_frame(4, 0, -1, 1'b0, 0, 3, bc, sc);
        n_cmp++; if (bc !== 14) begin n_fail++; $display("[TB] FAIL restart_busy_cycles got=%0d exp=14", bc); end
        n_cmp++; if (rden_cnt - rd0 !== 4) begin n_fail++; $display("[TB] FAIL restart_rden got=%0d exp=4", rden_cnt - rd0); end
        n_cmp++; if (rx_q.size() - rx0 !== 4) begin n_fail++; $display("[TB] FAIL restart_count got=%0d exp=4", rx_q.size() - rx0); end
        for (int i = 0; i < 4; i++) begin
            if (rx0 + i < rx_q.size()) begin
                n_cmp++;
                if (rx_q[rx0 + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL restart_byte%0d got=%h exp=%h", i, rx_q[rx0 + i], exp[i]); end
            end
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_no_queue got=%b exp=0", busy); end
        ack_flags();
    endtask

    task automatic test_reset_mid_frame();
        int rx0, bc, sc, k;
        logic [DATA_W-1:0] exp [3];
        write_bytes(4);
        rx0 = rx_q.size();
        @(negedge clk);
        frame_len = 8'd4; guard_interval = '0; fifo_count = LEN_W'(wr_ptr - rd_ptr);
        tx_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(rx_q.size() - rx0 == 1 && tx_valid) && k < 50) begin
            tx_ready = (rx_q.size() - rx0 == 0);
            k++;
            @(negedge clk);
        end
        n_cmp++; if (k >= 50) begin n_fail++; $display("[TB] FAIL midreset_reach_send got=timeout exp=second_byte_valid"); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_tx_valid got=%b exp=0", tx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
        n_cmp++; if (fifo_rden !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_rden got=%b exp=0", fifo_rden); end
        n_cmp++; if (done_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_irq got=%b exp=0", done_irq); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tx_ready = 1'b1;
        write_bytes(3);
        for (int i = 0; i < 3; i++) exp[i] = mem[rd_ptr + i];
        rx0 = rx_q.size();
        run_frame(3, 2, -1, 1'b0, 0, -1, bc, sc);
        n_cmp++; if (bc !== 13) begin n_fail++; $display("[TB] FAIL postreset_busy_cycles got=%0d exp=13", bc); end
        n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL postreset_done_irq got=%b exp=1", done_irq); end
        n_cmp++; if (rx_q.size() - rx0 !== 3) begin n_fail++; $display("[TB] FAIL postreset_count got=%0d exp=3", rx_q.size() - rx0); end
        for (int i = 0; i < 3; i++) begin
            if (rx0 + i < rx_q.size()) begin
                n_cmp++;
                if (rx_q[rx0 + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL postreset_byte%0d got=%h exp=%h", i, rx_q[rx0 + i], exp[i]); end
            end
        end
        ack_flags();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp [$];
        int len, guard, ovr, rx0, rd0, st0, bc, sc, bad, exp_bc;
        bit short_fifo;
        for (int it = 0; it < 10; it++) begin
            len   = $urandom_range(1, 24);
            guard = $urandom_range(0, 6);
            write_bytes(len);
            short_fifo = ($urandom_range(0, 3) == 0);
            ovr = short_fifo ? len - 1 : -1;
            exp.delete();
            for (int i = 0; i < len; i++) exp.push_back(mem[rd_ptr + i]);
            rx0 = rx_q.size(); rd0 = rden_cnt; st0 = stall_cnt;
            run_frame(len, guard, ovr, 1'b1, 0, -1, bc, sc);
            if (short_fifo) begin
                exp.delete();
                exp_bc = 1;
            end else begin
                exp_bc = 3 * len + guard + 2 + (stall_cnt - st0);
            end
            bad = 0;
            if (rx_q.size() - rx0 != exp.size()) bad++;
            for (int i = 0; i < exp.size() && rx0 + i < rx_q.size(); i++)
                if (rx_q[rx0 + i] !== exp[i]) bad++;
            n_cmp++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_bytes got=%0d_bytes/%0d_wrong exp=%0d_bytes", it, rx_q.size() - rx0, bad, exp.size()); end
            n_cmp++; if (rden_cnt - rd0 !== exp.size()) begin n_fail++; $display("[TB] FAIL rand%0d_rden got=%0d exp=%0d", it, rden_cnt - rd0, exp.size()); end
            n_cmp++; if (bc !== exp_bc) begin n_fail++; $display("[TB] FAIL rand%0d_busy_cycles got=%0d exp=%0d", it, bc, exp_bc); end
            n_cmp++; if (underrun !== short_fifo) begin n_fail++; $display("[TB] FAIL rand%0d_underrun got=%b exp=%b", it, underrun, short_fifo); end
            n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL rand%0d_done_irq got=%b exp=1", it, done_irq); end
            ack_flags();
        end
    endtask

    task automatic test_max_len();
        int rx0, rd0, bc, sc, bad;
        logic [DATA_W-1:0] exp [$];
        write_bytes(255);
        exp.delete();
        for (int i = 0; i < 255; i++) exp.push_back(mem[rd_ptr + i]);
        rx0 = rx_q.size(); rd0 = rden_cnt;
        run_frame(255, 0, -1, 1'b0, 0, -1, bc, sc);
        bad = 0;
        for (int i = 0; i < 255 && rx0 + i < rx_q.size(); i++)
            if (rx_q[rx0 + i] !== exp[i]) bad++;
        n_cmp++; if (rx_q.size() - rx0 !== 255) begin n_fail++; $display("[TB] FAIL max_count got=%0d exp=255", rx_q.size() - rx0); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL max_bytes got=%0d_wrong exp=0_wrong", bad); end
        n_cmp++; if (rden_cnt - rd0 !== 255) begin n_fail++; $display("[TB] FAIL max_rden got=%0d exp=255", rden_cnt - rd0); end
        n_cmp++; if (bc !== 767) begin n_fail++; $display("[TB] FAIL max_busy_cycles got=%0d exp=767", bc); end
        n_cmp++; if (done_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL max_done_irq got=%b exp=1", done_irq); end
        ack_flags();
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        frame_len      = '0;
        guard_interval = '0;
        fifo_count     = '0;
        tx_ready       = 1'b1;
        irq_ack        = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_guard_ack();
        test_ignored_start();
        test_reset_mid_frame();
        test_random();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
